// File: rtl/tremolo_mod_pkg.sv
// Shared widths and helpers for the tremolo stage and its rate divider.
// The LFO full-scale value is all ones at the LFO width.
package tremolo_mod_pkg;

  localparam int unsigned DefW  = 24;
  localparam int unsigned DefN  = 8;
  localparam int unsigned DefRw = 16;

  localparam logic [DefN-1:0] LfoMaxDef = {DefN{1'b1}};

  typedef logic [DefN-1:0] gain_t;

  // A rate of zero behaves exactly like a rate of one.
  function automatic logic [DefRw-1:0] rate_eff(input logic [DefRw-1:0] rate);
    return (rate == '0) ? DefRw'(1) : rate;
  endfunction

endpackage

// File: rtl/tremolo_mod_if.sv
// Sample-stream and control bundle between the tremolo stage and its neighbours.
// The master side drives samples and controls; the slave side is the effect.
interface tremolo_mod_if
  import tremolo_mod_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned N  = DefN,
  parameter int unsigned RW = DefRw
) ();

  logic          en;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic [N-1:0]  lfo;
  logic [N-1:0]  depth;
  logic [RW-1:0] rate;
  logic          lfo_nxt;
  logic          m_valid;
  logic [W-1:0]  m_data;

  modport master (
    output en, s_valid, s_data, lfo, depth, rate,
    input  lfo_nxt, m_valid, m_data
  );

  modport slave (
    input  en, s_valid, s_data, lfo, depth, rate,
    output lfo_nxt, m_valid, m_data
  );

endinterface

// File: rtl/tremolo_mod_rate_div.sv
// Counts accepted samples and emits a one-cycle LFO advance pulse every `rate` samples.
// Held cleared while the effect is disabled.
module tremolo_mod_rate_div #(
  parameter int unsigned RW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          tick_i,
  input  logic [RW-1:0] rate_i,
  output logic          lfo_nxt_o
);

  logic [RW-1:0] cnt_q, cnt_d;
  logic          nxt_q, nxt_d;
  logic [RW-1:0] rate_eff;
  logic [RW:0]   cnt_inc;

  always_comb begin
    rate_eff = (rate_i == '0) ? RW'(1) : rate_i;
    cnt_inc  = {1'b0, cnt_q} + (RW + 1)'(1);
    cnt_d    = cnt_q;
    nxt_d    = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      // >= rather than == so a rate lowered below the count fires on the next sample.
      if (cnt_inc >= {1'b0, rate_eff}) begin
        nxt_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      nxt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      nxt_q <= nxt_d;
    end
  end

  assign lfo_nxt_o = nxt_q;

endmodule

// File: rtl/tremolo_mod.sv
// Tremolo: three-stage gain pipeline driven by a triangle LFO and a depth control,
// with a bit-exact bypass of equal latency and the LFO advance divider.
module tremolo_mod
  import tremolo_mod_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned N  = DefN,
  parameter int unsigned RW = DefRw
) (
  input logic         clk,
  input logic         rst,
  tremolo_mod_if.slave bus_io
);

  localparam logic [N-1:0] LfoMax = {N{1'b1}};
  localparam int unsigned  PW     = W + N + 1;

  // Stage 1: sample capture and depth * (MAX - lfo).
  logic           v1_q, v1_d;
  logic           en1_q, en1_d;
  logic [W-1:0]   x1_q, x1_d;
  logic [2*N-1:0] p1_q, p1_d;
  logic [N-1:0]   lfo_inv;

  // Stage 2: gain.
  logic           v2_q, v2_d;
  logic           en2_q, en2_d;
  logic [W-1:0]   x2_q, x2_d;
  logic [N-1:0]   g2_q, g2_d;

  // Stage 3: output register.
  logic           mv_q, mv_d;
  logic [W-1:0]   md_q, md_d;
  logic signed [PW-1:0] prod;
  logic [W-1:0]   y;

  always_comb begin
    lfo_inv = LfoMax - bus_io.lfo;
    v1_d    = bus_io.s_valid;
    en1_d   = en1_q;
    x1_d    = x1_q;
    p1_d    = p1_q;
    if (bus_io.s_valid) begin
      en1_d = bus_io.en;
      x1_d  = bus_io.s_data;
      p1_d  = {{N{1'b0}}, bus_io.depth} * {{N{1'b0}}, lfo_inv};
    end
  end

  always_comb begin
    v2_d  = v1_q;
    en2_d = en2_q;
    x2_d  = x2_q;
    g2_d  = g2_q;
    if (v1_q) begin
      en2_d = en1_q;
      x2_d  = x1_q;
      g2_d  = LfoMax - N'(p1_q >> N);
    end
  end

  always_comb begin
    // Gain is at most MAX/2^N < 1, so the shifted product always fits in W bits.
    prod = PW'($signed(x2_q)) * PW'($signed({1'b0, g2_q}));
    y    = W'(prod >>> N);
    mv_d = v2_q;
    md_d = md_q;
    if (v2_q) begin
      md_d = en2_q ? y : x2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      en1_q <= 1'b0;
      x1_q  <= '0;
      p1_q  <= '0;
      v2_q  <= 1'b0;
      en2_q <= 1'b0;
      x2_q  <= '0;
      g2_q  <= '0;
      mv_q  <= 1'b0;
      md_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      en1_q <= en1_d;
      x1_q  <= x1_d;
      p1_q  <= p1_d;
      v2_q  <= v2_d;
      en2_q <= en2_d;
      x2_q  <= x2_d;
      g2_q  <= g2_d;
      mv_q  <= mv_d;
      md_q  <= md_d;
    end
  end

  assign bus_io.m_valid = mv_q;
  assign bus_io.m_data  = md_q;

  tremolo_mod_rate_div #(
    .RW(RW)
  ) u_rate_div (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (bus_io.en),
    .tick_i    (bus_io.s_valid),
    .rate_i    (bus_io.rate),
    .lfo_nxt_o (bus_io.lfo_nxt)
  );

endmodule

// File: tb/tb_tremolo_mod.sv
// Directed bench for tremolo_mod: gain vectors from a table, then hand-written
// sequences for reset, the rate divider and a mid-stream reset.
module tb_tremolo_mod;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tremolo_mod_if #(.W(24), .N(8), .RW(16)) bus ();

  tremolo_mod #(
    .W (24),
    .N (8),
    .RW(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  typedef struct {
    logic       en;
    logic [7:0] depth;
    logic [7:0] lfo;
    int         x;
    int         y;
    logic       nxt;
  } vec_t;

  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] md();
    return 32'($signed(bus.m_data));
  endfunction

  initial begin
    // en, depth, lfo, x, expected y, expected lfo_nxt (rate = 1)
    vecs[0]  = '{1'b0, 8'd0,   8'd0,   1000,     1000,     1'b0};
    vecs[1]  = '{1'b0, 8'd200, 8'd10,  -1000,    -1000,    1'b0};
    vecs[2]  = '{1'b0, 8'd255, 8'd0,   8388607,  8388607,  1'b0};
    vecs[3]  = '{1'b1, 8'd0,   8'd0,   8388607,  8355839,  1'b1};
    vecs[4]  = '{1'b1, 8'd255, 8'd0,   -25600,   -100,     1'b1};
    vecs[5]  = '{1'b1, 8'd255, 8'd255, -25600,   -25500,   1'b1};
    vecs[6]  = '{1'b1, 8'd128, 8'd0,   25600,    12800,    1'b1};
    vecs[7]  = '{1'b1, 8'd255, 8'd128, -256,     -129,     1'b1};
    vecs[8]  = '{1'b1, 8'd0,   8'd77,  -8388608, -8355840, 1'b1};
    vecs[9]  = '{1'b1, 8'd255, 8'd0,   -1,       -1,       1'b1};
    vecs[10] = '{1'b1, 8'd255, 8'd0,   255,      0,        1'b1};

    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 24'd1234;
    bus.lfo     = 8'd0;
    bus.depth   = 8'd0;
    bus.rate    = 16'd1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_m_valid", 32'(bus.m_valid), 0);
      chk("rst_m_data", md(), 0);
      chk("rst_lfo_nxt", 32'(bus.lfo_nxt), 0);
    end
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    tick();

    // Controls are scrambled after capture to show only stage-1 values matter.
    for (int i = 0; i < 11; i++) begin
      bus.en      = vecs[i].en;
      bus.depth   = vecs[i].depth;
      bus.lfo     = vecs[i].lfo;
      bus.s_data  = 24'(vecs[i].x);
      bus.s_valid = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      bus.depth   = ~vecs[i].depth;
      bus.lfo     = ~vecs[i].lfo;
      bus.s_data  = 24'h555555;
      chk("vec_lfo_nxt", 32'(bus.lfo_nxt), 32'(vecs[i].nxt));
      chk("vec_early_valid", 32'(bus.m_valid), 0);
      tick();
      chk("vec_early_valid2", 32'(bus.m_valid), 0);
      tick();
      chk("vec_m_valid", 32'(bus.m_valid), 1);
      chk("vec_m_data", md(), vecs[i].y);
      tick();
      chk("vec_valid_drop", 32'(bus.m_valid), 0);
      chk("vec_data_hold", md(), vecs[i].y);
    end

    // Rate divider: every 4th sample, then every sample with rate 0.
    bus.en      = 1'b1;
    bus.depth   = 8'd0;
    bus.rate    = 16'd4;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rate4_nxt", 32'(bus.lfo_nxt), (i % 4 == 3) ? 1 : 0);
    end
    bus.rate = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rate0_nxt", 32'(bus.lfo_nxt), 1);
    end
    bus.s_valid = 1'b0;
    tick();
    chk("idle_no_nxt", 32'(bus.lfo_nxt), 0);

    // Rate lowered 10 -> 2 with the count at 5.
    bus.rate    = 16'd10;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rate10_nxt", 32'(bus.lfo_nxt), 0);
    end
    bus.rate = 16'd2;
    tick();
    chk("rate_drop_nxt", 32'(bus.lfo_nxt), 1);
    tick();
    chk("rate2_nxt_a", 32'(bus.lfo_nxt), 0);
    tick();
    chk("rate2_nxt_b", 32'(bus.lfo_nxt), 1);

    // Disabling clears the count and suppresses the pulse.
    bus.rate = 16'd3;
    tick();
    chk("pre_dis_nxt", 32'(bus.lfo_nxt), 0);
    bus.en = 1'b0;
    tick();
    chk("dis_nxt", 32'(bus.lfo_nxt), 0);
    bus.en = 1'b1;
    tick();
    chk("reen_nxt_a", 32'(bus.lfo_nxt), 0);
    tick();
    chk("reen_nxt_b", 32'(bus.lfo_nxt), 0);
    tick();
    chk("reen_nxt_c", 32'(bus.lfo_nxt), 1);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back bypass samples with reset held from the 5th onward.
    bus.en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.s_data  = 24'((k + 1) * 10);
      bus.s_valid = 1'b1;
      rst         = (k >= 4);
      tick();
      if (k < 2) begin
        chk("b2b_early", 32'(bus.m_valid), 0);
      end else if (k < 4) begin
        chk("b2b_m_valid", 32'(bus.m_valid), 1);
        chk("b2b_m_data", md(), (k - 1) * 10);
      end else begin
        chk("b2b_dropped", 32'(bus.m_valid), 0);
        chk("b2b_rst_data", md(), 0);
        chk("b2b_rst_nxt", 32'(bus.lfo_nxt), 0);
      end
    end
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    chk("post_rst_quiet", 32'(bus.m_valid), 0);
    bus.s_data  = 24'd99;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    chk("post_rst_lat1", 32'(bus.m_valid), 0);
    tick();
    chk("post_rst_lat2", 32'(bus.m_valid), 0);
    tick();
    chk("post_rst_valid", 32'(bus.m_valid), 1);
    chk("post_rst_data", md(), 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
